// File: rtl/ramio_pkg.sv
// ramio_pkg -- shared encodings and default IO map for the ramio memory/IO back end.
// Rev 1.0
`default_nettype none

package ramio_pkg;

  // Write sizes, also used for read_type[1:0]
  localparam logic [1:0] WT_NONE = 2'b00;
  localparam logic [1:0] WT_BYTE = 2'b01;
  localparam logic [1:0] WT_HALF = 2'b10;
  localparam logic [1:0] WT_WORD = 2'b11;

  localparam logic [1:0] RS_NONE = 2'b00;
  localparam logic [1:0] RS_BYTE = 2'b01;
  localparam logic [1:0] RS_HALF = 2'b10;
  localparam logic [1:0] RS_WORD = 2'b11;

  localparam int RT_SIGN_BIT = 2;

  localparam logic [31:0] DEFAULT_ADDRESS_UART_OUT = 32'hFFFF_FFF8;
  localparam logic [31:0] DEFAULT_ADDRESS_LED      = 32'hFFFF_FFFC;

  // {address, read_type, write_type}
  localparam int KEY_W = 37;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } ram_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/ramio_uart_tx.sv
// uart_tx -- 8N1 serial transmitter; go is ignored while a frame is in flight.
// Rev 1.0
`default_nettype none

module uart_tx
  import ramio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] data,
  output logic       tx,
  output logic       active
);

  localparam int CPB = (CLKS_PER_BIT < 1) ? 1 : CLKS_PER_BIT;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          bit_done;

  assign bit_done = (cnt_q == CNT_LAST);
  assign tx       = tx_q;
  assign active   = (state_q != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q != TX_IDLE) cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
      case (state_q)
        TX_IDLE: if (go) begin
          state_q <= TX_START;
          tx_q    <= 1'b0;
          shift_q <= data;
          cnt_q   <= '0;
        end
        TX_START: if (bit_done) begin
          state_q <= TX_DATA;
          tx_q    <= shift_q[0];
          shift_q <= {1'b0, shift_q[7:1]};
          bit_q   <= '0;
        end
        TX_DATA: if (bit_done) begin
          if (bit_q == 3'd7) begin
            state_q <= TX_STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end
        end
        TX_STOP: if (bit_done) state_q <= TX_IDLE;
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ramio.sv
// ramio -- block-RAM and LED/UART back end for the core's RAMIO request port.
// Rev 1.0
`default_nettype none

module ramio
  import ramio_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH   = 12,
  parameter int          CLK_FREQ         = 27_000_000,
  parameter int          BAUD_RATE        = 115200,
  parameter logic [31:0] ADDRESS_UART_OUT = DEFAULT_ADDRESS_UART_OUT,
  parameter logic [31:0] ADDRESS_LED      = DEFAULT_ADDRESS_LED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  write_type,
  input  logic [2:0]  read_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic [3:0]  led,
  output logic        uart_tx
);

  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;

  logic [KEY_W-1:0]          req_key;
  logic [KEY_W-1:0]          key_q;
  logic                      serviced_q;
  ram_state_e                state_q;
  logic                      ready_q;
  logic [31:0]               data_out_q;
  logic [3:0]                led_q;
  logic                      is_write, is_read, is_uart, is_led, is_io;
  logic                      accept, ram_we, uart_active;
  logic [RAM_ADDR_WIDTH-1:0] word_idx;
  logic [3:0]                wr_be;
  logic [31:0]               wr_data;
  logic [31:0]               mem [DEPTH];
  logic [31:0]               ram_rdata_q;
  logic [31:0]               rd_addr;
  logic [2:0]                rd_type;
  logic [31:0]               rd_src, rd_shift, rd_ext;

  assign req_key  = {address, read_type, write_type};
  assign is_write = (write_type != WT_NONE);
  assign is_read  = !is_write && (read_type[1:0] != RS_NONE);
  assign is_uart  = (address == ADDRESS_UART_OUT);
  assign is_led   = (address == ADDRESS_LED);
  assign is_io    = is_uart || is_led;
  assign word_idx = address[RAM_ADDR_WIDTH+1:2];

  assign busy   = (state_q == ST_READ) || uart_active;
  // A held request keeps the same key, so it is never accepted twice.
  assign accept = enable && !busy && (is_write || is_read) &&
                  (!serviced_q || (req_key != key_q));
  assign ram_we = accept && is_write && !is_io;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = data_in;
    case (write_type)
      WT_BYTE: begin
        wr_be   = 4'b0001 << address[1:0];
        wr_data = {4{data_in[7:0]}};
      end
      WT_HALF: begin
        wr_be   = address[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{data_in[15:0]}};
      end
      WT_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (accept && is_read) ram_rdata_q <= mem[word_idx];
  end

  // During READ the live inputs may already have moved on; decode from the latched key.
  assign rd_addr = key_q[KEY_W-1 -: 32];
  assign rd_type = key_q[4:2];

  always_comb begin
    rd_src = ram_rdata_q;
    if (rd_addr == ADDRESS_LED)           rd_src = {28'b0, ~led_q};
    else if (rd_addr == ADDRESS_UART_OUT) rd_src = 32'b0;

    case (rd_type[1:0])
      RS_BYTE: rd_shift = rd_src >> {rd_addr[1:0], 3'b000};
      RS_HALF: rd_shift = rd_src >> {rd_addr[1], 4'b0000};
      default: rd_shift = rd_src;
    endcase

    case (rd_type[1:0])
      RS_BYTE: rd_ext = rd_type[RT_SIGN_BIT] ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                             : {24'b0, rd_shift[7:0]};
      RS_HALF: rd_ext = rd_type[RT_SIGN_BIT] ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                             : {16'b0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      serviced_q <= 1'b0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      led_q      <= 4'b1111;
    end else begin
      if (!enable) serviced_q <= 1'b0;
      if (accept) begin
        key_q      <= req_key;
        serviced_q <= 1'b1;
        ready_q    <= 1'b0;
        if (is_read) state_q <= ST_READ;
        if (is_write && is_led) led_q <= ~data_in[3:0];
      end
      if (state_q == ST_READ) begin
        data_out_q <= rd_ext;
        ready_q    <= 1'b1;
        state_q    <= ST_IDLE;
      end
    end
  end

  assign data_out_ready = ready_q && enable && (req_key == key_q);
  assign data_out       = data_out_q;
  assign led            = led_q;

  uart_tx #(
    .CLKS_PER_BIT(CLK_FREQ / BAUD_RATE)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (accept && is_write && is_uart),
    .data  (data_in[7:0]),
    .tx    (uart_tx),
    .active(uart_active)
  );

endmodule

`default_nettype wire
